uart_rx_fifo_wb: RTL
====================

# uart_rx_fifo_wb

Wishbone-slave receive buffer placed directly downstream of the UART receiver. It captures each byte from the receiver's one-cycle data-valid strobe into a synchronous FIFO, so the CPU can read bytes later without losing characters arriving back-to-back. It exposes data, status and control registers and a level/overrun interrupt to the core.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..128
- AW, $clog2(DEPTH), pointer width (derived; do not override)
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset; one clock; reset is synchronous and active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only [3:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_stall_o  out  1  constant 0
- wb_ack_o  out  1  registered acknowledge
- wb_dat_o  out  32  registered read data
- wb_err_o  out  1  constant 0
- rx_byte_i  in  8  received byte from UART receiver
- rx_valid_i  in  1  one-cycle strobe; rx_byte_i valid
- irq_o  out  1  registered interrupt, active-high

## Operation
- Registers (adr[3:2]): 0 DATA (R), 1 STATUS (R/W1C), 2 CTRL (R/W), 3 reserved (reads 0, writes ignored, still acked).
- DATA read: returns {23'b0, valid, byte}; valid=1 and head byte when non-empty, then pops. Empty: returns 0, no pointer change. DATA writes ignored.
- STATUS: [15:8] count (zero-extended AW+1 bits), [2] overrun (sticky), [1] full, [0] empty. Writing 1 to bit 2 with sel[0] clears overrun; other bits read-only.
- CTRL: [0] irq_en, [1] flush (write-1, self-clearing, reads 0), [15:8] threshold. sel[0] gates [7:0], sel[1] gates [15:8].
- Push: rx_valid_i=1 and not full → write rx_byte_i at wr_ptr, wr_ptr+1 mod DEPTH.
- Push when full without same-edge pop → byte dropped, overrun set.
- Push and pop same edge: both occur, count unchanged; when full, this is not an overrun.
- Overrun set and W1C on same edge: set wins.
- Flush: pointers and count to 0 at that edge; concurrent push dropped (no overrun); overrun flag untouched.
- irq_o next cycle = irq_en & ((count >= max(threshold,1)) | overrun); threshold > DEPTH means only overrun interrupts.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH).

## Timing
- Request accepted at edge N when wb_cyc_i & wb_stb_i & ~wb_ack_o; wb_ack_o=1 and wb_dat_o valid in cycle N+1 for exactly one cycle; the next request can be accepted at edge N+2.
- Register side effects (pop, W1C, CTRL write, flush) take effect at edge N.
- STATUS read at edge N reflects state before edge N's push/pop.
- Push to DATA-visible latency: byte pushed at edge P is readable by a request accepted at edge P+1.
- wb_ack_o is 0 whenever wb_cyc_i was 0 at the preceding edge; dropping cyc mid-cycle aborts nothing already accepted.
- Reset (wb_rst_i=0 at an edge): pointers, count, overrun, CTRL to 0; wb_ack_o=0, wb_dat_o=0, irq_o=0; wb_stall_o=wb_err_o=0 always. A transaction in flight is dropped without ack; rx_valid_i during reset is ignored.

## Structure
- Package uart_rx_fifo_pkg: register offsets (DATA/STATUS/CTRL), STATUS and CTRL bit positions, field widths.
- Sub-module sync_fifo (DEPTH, WIDTH=8): push/pop/flush in; rd_data, count, full, empty out; same-edge push+pop when full allowed. The wrapper holds Wishbone decode, registers, overrun and irq logic.

## Test plan
- After reset, read STATUS → 0x00000001; CTRL → 0; irq_o=0; ack one cycle after stb.
- Push 0x41,0x42,0x43; read DATA thrice → 0x141,0x142,0x143; fourth read → 0x000; STATUS → 0x1.
- DEPTH=16: push 17 bytes 0x00..0x10 → STATUS 0x1006 (count 16, overrun, full); reads return 0x00..0x0F; write STATUS 0x4 → overrun clears.
- CTRL=0x0301 (threshold 3, irq_en): push 2 bytes → irq_o=0; third byte → irq_o=1 the following cycle; one DATA read → irq_o=0.
- Full FIFO, rx_valid_i on the same edge a DATA read is accepted → count stays 16, overrun stays 0, new byte appears last.
- Push 5 bytes, write CTRL bit1 with concurrent rx_valid_i → STATUS=0x1, pushed byte lost; assert reset during a pending read → no ack is issued.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Register map, bit positions and field widths shared by the UART receive buffer.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  localparam int DATA_VALID_BIT = 8;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_THR_LSB = 8;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;
  localparam int THR_W  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // rst is active-low; flush discards contents and any same-edge push
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo_wb.sv
// Wishbone register front-end for the UART receive FIFO: DATA/STATUS/CTRL, overrun and irq.
module uart_rx_fifo_wb
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_err_o,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic        irq_o
);

  // Handshake: a request is taken on any edge with cyc & stb & ~ack; ack and read
  // data follow for exactly one cycle, and all side effects happen at the taking edge.
  logic             req;
  reg_e             reg_sel;
  logic [7:0]       head_byte;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             overrun;
  logic             irq_en;
  logic [THR_W-1:0] threshold;
  logic             pop;
  logic             flush;
  logic             w1c;
  logic             ovr_set;
  logic             ctrl_wr;
  logic [8:0]       thr_eff;
  logic [31:0]      rd_word;
  logic             unused_ok;

  assign wb_stall_o = 1'b0;
  assign wb_err_o   = 1'b0;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign reg_sel = reg_e'(wb_adr_i[3:2]);
  assign pop     = req & ~wb_we_i & (reg_sel == REG_DATA) & ~empty;
  assign ctrl_wr = req & wb_we_i & (reg_sel == REG_CTRL);
  assign flush   = ctrl_wr & wb_sel_i[0] & wb_dat_i[CTRL_FLUSH];
  assign w1c     = req & wb_we_i & (reg_sel == REG_STATUS) & wb_sel_i[0] & wb_dat_i[STAT_OVERRUN];
  // A full FIFO still accepts a byte when the CPU pops on the same edge
  assign ovr_set = rx_valid_i & full & ~pop & ~flush;
  assign thr_eff = (threshold == '0) ? 9'd1 : {1'b0, threshold};

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16],
                       wb_dat_i[7:3], wb_sel_i[3:2]};

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (rx_valid_i),
    .pop     (pop),
    .flush   (flush),
    .wr_data (rx_byte_i),
    .rd_data (head_byte),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    rd_word = '0;
    if (!wb_we_i) begin
      case (reg_sel)
        REG_DATA: if (!empty) rd_word = {23'b0, 1'b1, head_byte};
        REG_STATUS: begin
          rd_word[STAT_CNT_LSB +: CNT_W] = CNT_W'(count);
          rd_word[STAT_OVERRUN]          = overrun;
          rd_word[STAT_FULL]             = full;
          rd_word[STAT_EMPTY]            = empty;
        end
        REG_CTRL: begin
          rd_word[CTRL_THR_LSB +: THR_W] = threshold;
          rd_word[CTRL_IRQ_EN]           = irq_en;
        end
        default: rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      irq_o     <= 1'b0;
      overrun   <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_word : '0;
      irq_o    <= irq_en & ((9'(count) >= thr_eff) | overrun);
      if (ovr_set)  overrun <= 1'b1;
      else if (w1c) overrun <= 1'b0;
      if (ctrl_wr && wb_sel_i[0]) irq_en    <= wb_dat_i[CTRL_IRQ_EN];
      if (ctrl_wr && wb_sel_i[1]) threshold <= wb_dat_i[CTRL_THR_LSB +: THR_W];
    end
  end

endmodule
